// File: rtl/skew_pkg.sv
// Shared types for the skew buffer: FSM states, lane timing modes and the
// per-lane delay helper used when sizing and steering the lane chains.
package skew_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  typedef enum logic {
    SKEW   = 1'b0,
    DESKEW = 1'b1
  } mode_t;

  // Extra delay (beyond the single output register) applied to lane k.
  function automatic int lane_delay(input mode_t m, input int lanes, input int k);
    return (m == DESKEW) ? (lanes - 1 - k) : k;
  endfunction

endpackage

// File: rtl/skew_lane.sv
// One lane of the skew buffer: an en-gated shift chain of data+valid whose
// output is always the last stage; inj picks which stage the input enters.
module skew_lane #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 32,
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [IW-1:0]     inj,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data
);

  logic [DATA_W-1:0] data_p [DEPTH];
  logic [DEPTH-1:0]  vld_p;

  // Stages ahead of the injection point are flushed with bubbles so that
  // a short delay never exposes stale words from a previous tile.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int j = 0; j < DEPTH; j++) begin
        data_p[j] <= '0;
      end
      vld_p <= '0;
    end else if (en) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (IW'(j) < inj) begin
          data_p[j] <= '0;
          vld_p[j]  <= 1'b0;
        end else if (IW'(j) == inj) begin
          data_p[j] <= in_vld ? in_data : '0;
          vld_p[j]  <= in_vld;
        end else begin
          data_p[j] <= data_p[(j > 0) ? j - 1 : 0];
          vld_p[j]  <= vld_p[(j > 0) ? j - 1 : 0];
        end
      end
    end
  end

  assign out_data = data_p[DEPTH-1];
  assign out_vld  = vld_p[DEPTH-1];

endmodule

// File: rtl/skew_buffer.sv
// Row-to-diagonal skew buffer with tile framing (IDLE/STREAM/DRAIN).
// Optional deskew mode is enabled by defining SKEW_BUFFER_DESKEW_EN.
module skew_buffer
  import skew_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
`ifdef SKEW_BUFFER_DESKEW_EN
  input  logic              mode,
`endif
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [DATA_W-1:0] in_data [LANES],
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data [LANES],
  output logic [LANES-1:0]  out_valid,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(LANES) + 1;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              accept;

  assign accept   = en & in_valid & in_ready;
  assign in_ready = (state_q != DRAIN);
  assign busy     = (state_q != IDLE);
  assign out_last = (state_q == DRAIN) && (cnt_q == '0);
  assign done     = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // The drain count covers the longest lane, so out_last lines up with the
  // final word of the tile regardless of lane ordering.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE, STREAM: begin
        if (accept) begin
          if (in_last) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(LANES - 1);
          end else begin
            state_d = STREAM;
          end
        end
      end
      DRAIN: begin
        if (en) begin
          if (cnt_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef SKEW_BUFFER_DESKEW_EN
  localparam int IW = $clog2(LANES);

  mode_t mode_q;
  mode_t mode_eff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q <= SKEW;
    end else if (accept && (state_q == IDLE)) begin
      mode_q <= mode_t'(mode);
    end
  end

  // The first row of a tile must already use the mode being latched with it.
  assign mode_eff = (state_q == IDLE) ? mode_t'(mode) : mode_q;
`endif

  for (genvar k = 0; k < LANES; k++) begin : g_lane
`ifdef SKEW_BUFFER_DESKEW_EN
    localparam int DEPTH = LANES;
    logic [IW-1:0] inj;
    assign inj = IW'(LANES - 1 - lane_delay(mode_eff, LANES, k));
`else
    localparam int DEPTH = lane_delay(SKEW, LANES, k) + 1;
    localparam int LIW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    logic [LIW-1:0] inj;
    assign inj = '0;
`endif

    skew_lane #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .inj      (inj),
      .in_vld   (accept),
      .in_data  (in_data[k]),
      .out_vld  (out_valid[k]),
      .out_data (out_data[k])
    );
  end

endmodule

// File: tb/tb_skew_buffer.sv
// Directed bench for skew_buffer (LANES=4, DATA_W=32); deskew case runs when
// SKEW_BUFFER_DESKEW_EN is defined.
module tb_skew_buffer;

  localparam int LANES  = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              en = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_last = 1'b0;
  logic [DATA_W-1:0] in_data [LANES];
  logic              in_ready;
  logic [DATA_W-1:0] out_data [LANES];
  logic [LANES-1:0]  out_valid;
  logic              out_last;
  logic              busy;
  logic              done;
`ifdef SKEW_BUFFER_DESKEW_EN
  logic              mode = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  skew_buffer #(
    .LANES  (LANES),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
`ifdef SKEW_BUFFER_DESKEW_EN
    .mode      (mode),
`endif
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".out_valid"}, out_valid, 0);
    for (int k = 0; k < LANES; k++) begin
      chk($sformatf("%s.out_data%0d", tag, k), out_data[k], 0);
    end
    chk({tag, ".out_last"}, out_last, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".in_ready"}, in_ready, 1);
  endtask

  function automatic logic [DATA_W-1:0] word(input int s, input int k);
    return DATA_W'(32'h10 * s + k + 1);
  endfunction

  task automatic drive_slot(input int s, input bit valid, input bit last);
    in_valid = valid;
    in_last  = last;
    for (int k = 0; k < LANES; k++) begin
      in_data[k] = valid ? word(s, k) : 32'hFF;
    end
  endtask

  task automatic drive_none();
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int k = 0; k < LANES; k++) in_data[k] = '0;
  endtask

  // Expected outputs after e accepted en-cycles of a tile with nslots slots.
  task automatic chk_cycle(input string tag, input int e, input bit last_en,
                           input int nslots, input int bub);
    int  s;
    bit  v;
    for (int k = 0; k < LANES; k++) begin
      s = e - 1 - k;
      v = (s >= 0) && (s < nslots) && (s != bub);
      chk($sformatf("%s.e%0d.vld%0d", tag, e, k), out_valid[k], v);
      chk($sformatf("%s.e%0d.dat%0d", tag, e, k), out_data[k], v ? word(s, k) : 0);
    end
    chk($sformatf("%s.e%0d.last", tag, e), out_last, e == nslots + 3);
    chk($sformatf("%s.e%0d.busy", tag, e), busy, (e >= 1) && (e <= nslots + 3));
    chk($sformatf("%s.e%0d.done", tag, e), done, (e == nslots + 4) && last_en);
  endtask

  task automatic run_tile(input string tag, input int nslots, input int bub,
                          input int stall_at, input int stall_len, input bit poke);
    int e;
    int c;
    bit cur_en;
    e = 0;
    c = 0;
    while (e < nslots + 5) begin
      cur_en = !((c >= stall_at) && (c < stall_at + stall_len));
      en = cur_en;
      chk($sformatf("%s.e%0d.rdy", tag, e), in_ready, !((e >= nslots) && (e <= nslots + 3)));
      if (e < nslots) begin
        drive_slot(e, e != bub, e == nslots - 1);
      end else if (poke && (e <= nslots + 3)) begin
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int k = 0; k < LANES; k++) in_data[k] = 32'hDEAD0000 + k;
      end else begin
        drive_none();
      end
      tick();
      c++;
      if (cur_en) e++;
      chk_cycle(tag, e, cur_en, nslots, bub);
    end
    en = 1'b1;
    drive_none();
  endtask

  initial begin
    drive_none();
    #3;
    chk_idle("reset");
    repeat (2) tick();
    rst = 1'b1;
    en  = 1'b1;
    chk_idle("post_reset");

    run_tile("basic", 3, -1, 1000, 0, 1'b0);
    run_tile("stall", 3, -1, 1, 3, 1'b0);
    run_tile("poke", 3, -1, 1000, 0, 1'b1);
    run_tile("bubble", 4, 1, 1000, 0, 1'b0);
    run_tile("single", 1, -1, 1000, 0, 1'b0);

    // Reset two cycles after the last row is accepted.
    for (int s = 0; s < 3; s++) begin
      drive_slot(s, 1'b1, s == 2);
      tick();
    end
    drive_none();
    tick();
    tick();
    chk("rst_mid.pre_vld", out_valid, 4'b1100);
    chk("rst_mid.pre_busy", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    chk_idle("rst_mid.async");
    tick();
    tick();
    chk_idle("rst_mid.held");
    #2;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("rst_mid.after%0d", i));
    end

`ifdef SKEW_BUFFER_DESKEW_EN
    mode     = 1'b1;
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int k = 0; k < LANES; k++) in_data[k] = 32'hA;
    tick();
    drive_none();
    mode = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      for (int k = 0; k < LANES; k++) begin
        chk($sformatf("deskew.e%0d.vld%0d", e, k), out_valid[k], e == LANES - k);
        chk($sformatf("deskew.e%0d.dat%0d", e, k), out_data[k], (e == LANES - k) ? 32'hA : 0);
      end
      chk($sformatf("deskew.e%0d.last", e), out_last, e == 4);
      chk($sformatf("deskew.e%0d.done", e), done, e == 5);
      tick();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
